dpm_input_conditioner: RTL

//  Upstream front end of the DPM unit. Synchronises the raw ui_in control bits,

---
 rtl/dpm_input_conditioner.sv | 106 ++++++++++
 1 files changed

// File: rtl/dpm_input_conditioner.sv
// Front end of the DPM unit: two-flop synchroniser, per-bit debounce and a
// valid/ready change-event port that merges updates while the consumer stalls.
module dpm_input_conditioner #(
  parameter int              WIDTH     = 8,
  parameter int              DEBOUNCE  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'hF2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [WIDTH-1:0] evt_data_o,
  output logic [WIDTH-1:0] evt_mask_o,
  output logic             merged_o,
  input  logic             clr_merged_i
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] upd;
  logic             any_upd;

  logic             valid_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] mask_nxt;
  logic             merged_nxt;

  // A bit is accepted only after differing from stable for DEBOUNCE enabled
  // cycles in a row; any agreement or a disabled cycle restarts the count.
  always_comb begin
    stable_nxt = stable_o;
    upd        = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (ena && (s2[i] != stable_o[i])) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = s2[i];
          upd[i]        = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign any_upd = |upd;

  always_comb begin
    valid_nxt  = evt_valid_o;
    data_nxt   = evt_data_o;
    mask_nxt   = evt_mask_o;
    merged_nxt = merged_o;
    if (any_upd && (!evt_valid_o || evt_ready_i)) begin
      valid_nxt = 1'b1;
      data_nxt  = stable_nxt;
      mask_nxt  = upd;
    end else if (any_upd) begin
      // Stalled: fold the new change into the pending event rather than drop it.
      data_nxt   = stable_nxt;
      mask_nxt   = evt_mask_o | upd;
      merged_nxt = 1'b1;
    end else if (evt_valid_o && evt_ready_i) begin
      valid_nxt = 1'b0;
      mask_nxt  = '0;
    end
    if (clr_merged_i) begin
      merged_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= RESET_VAL;
      s2          <= RESET_VAL;
      stable_o    <= RESET_VAL;
      evt_data_o  <= RESET_VAL;
      evt_valid_o <= 1'b0;
      evt_mask_o  <= '0;
      merged_o    <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= raw_i;
      s2          <= s1;
      stable_o    <= stable_nxt;
      evt_valid_o <= valid_nxt;
      evt_data_o  <= data_nxt;
      evt_mask_o  <= mask_nxt;
      merged_o    <= merged_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule
